// File: rtl/imem_program_encoder.sv
// rtl/imem_program_encoder.sv - packs field-level requests into MIPS R/I/J words and loads them into imem
// Holds the CPU in reset until the last word of the program has been written.
module imem_program_encoder #(
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [5:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wd,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              overflow,
  output logic              fmt_err,
  output logic              cpu_reset
);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} stateT;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  stateT             state, stateNext;
  logic              started;
  logic              lastReg;
  logic [ADDR_W-1:0] wrPtr;
  logic [ADDR_W-1:0] addrReg;
  logic [31:0]       wdReg;
  logic [ADDR_W:0]   cntReg;
  logic [ADDR_W:0]   cntInc;
  logic              ovfReg;
  logic              fmtErrReg;
  logic              accept;
  logic              legal;
  logic [31:0]       encWord;

  assign in_ready  = started && (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign legal     = (in_fmt != 2'd3);
  assign cntInc    = cntReg + 1'b1;

  assign imem_we   = (state == WRITE);
  assign imem_addr = addrReg;
  assign imem_wd   = wdReg;
  assign count     = cntReg;
  assign done      = (state == DONE);
  assign overflow  = ovfReg;
  assign fmt_err   = fmtErrReg;
  assign cpu_reset = ~done;

  always_comb begin
    encWord = 32'd0;
    case (in_fmt)
      2'd0:    encWord = {6'b0, in_rs, in_rt, in_rd, in_shamt, in_funct};
      2'd1:    encWord = {in_op, in_rs, in_rt, in_imm};
      2'd2:    encWord = {in_op, in_target};
      default: encWord = 32'd0;
    endcase
  end

  // The top bit of cntInc marks the write that fills the whole memory.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (legal)        stateNext = WRITE;
          else if (in_last) stateNext = DONE;
        end
      end
      WRITE: begin
        if (lastReg || cntInc[ADDR_W]) stateNext = DONE;
        else                           stateNext = IDLE;
      end
      DONE:    stateNext = DONE;
      default: stateNext = IDLE;
    endcase
  end

  // wrPtr is the next free word; addrReg only moves at a legal transfer so the
  // address seen by imem stays put while the strobe is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      started   <= 1'b0;
      lastReg   <= 1'b0;
      wrPtr     <= BASE;
      addrReg   <= BASE;
      wdReg     <= 32'd0;
      cntReg    <= '0;
      ovfReg    <= 1'b0;
      fmtErrReg <= 1'b0;
    end else begin
      state   <= stateNext;
      started <= 1'b1;
      if (accept) begin
        if (legal) begin
          addrReg <= wrPtr;
          wdReg   <= encWord;
          lastReg <= in_last;
        end else begin
          fmtErrReg <= 1'b1;
        end
      end
      if (state == WRITE) begin
        wrPtr  <= wrPtr + 1'b1;
        cntReg <= cntInc;
        if (cntInc[ADDR_W] && !lastReg) ovfReg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_program_encoder.sv
// tb/tb_imem_program_encoder.sv - directed self-checking bench for imem_program_encoder
// Instance A uses the default depth, instance B a 4-word memory for the full/overflow cases.
module tb_imem_program_encoder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic [1:0]  in_fmt = '0;
  logic [5:0]  in_op = '0;
  logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [5:0]  in_funct = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;
  logic        in_last = 1'b0;

  logic        aReady, aWe, aDone, aOvf, aFmtErr, aCpuRst;
  logic [5:0]  aAddr;
  logic [31:0] aWd;
  logic [6:0]  aCount;
  logic        bReady, bWe, bDone, bOvf, bFmtErr, bCpuRst;
  logic [1:0]  bAddr;
  logic [31:0] bWd;
  logic [2:0]  bCount;

  imem_program_encoder #(.ADDR_W(6), .BASE_ADDR(0)) dutA (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(aReady),
    .in_fmt(in_fmt), .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .in_last(in_last), .imem_we(aWe), .imem_addr(aAddr), .imem_wd(aWd), .count(aCount),
    .done(aDone), .overflow(aOvf), .fmt_err(aFmtErr), .cpu_reset(aCpuRst)
  );

  imem_program_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dutB (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(bReady),
    .in_fmt(in_fmt), .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .in_last(in_last), .imem_we(bWe), .imem_addr(bAddr), .imem_wd(bWd), .count(bCount),
    .done(bDone), .overflow(bOvf), .fmt_err(bFmtErr), .cpu_reset(bCpuRst)
  );

  int passCnt = 0;
  int totalCnt = 0;

  logic [31:0] memA [64];
  logic [31:0] memB [4];
  int wrA = 0, wrB = 0, dblA = 0, dblB = 0;
  logic prevWeA = 1'b0, prevWeB = 1'b0;

  // Imem model: one capture per strobe cycle, and count any strobe lasting two cycles.
  always @(negedge clk) begin
    if (!reset) begin
      if (aWe) begin
        memA[aAddr] = aWd;
        wrA++;
        if (prevWeA) dblA++;
      end
      if (bWe) begin
        memB[bAddr] = bWd;
        wrB++;
        if (prevWeB) dblB++;
      end
    end
    prevWeA = aWe && !reset;
    prevWeB = bWe && !reset;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    totalCnt++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else passCnt++;
  endtask

  task automatic doReset();
    in_valid = 1'b0;
    in_last  = 1'b0;
    reset    = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", aReady, 0);
    check("rst_we", aWe, 0);
    check("rst_addr", aAddr, 0);
    check("rst_wd", aWd, 0);
    check("rst_count", aCount, 0);
    check("rst_done", aDone, 0);
    check("rst_ovf", aOvf, 0);
    check("rst_fmterr", aFmtErr, 0);
    check("rst_cpurst", aCpuRst, 1);
    check("rst_b_ovf", bOvf, 0);
    for (int i = 0; i < 64; i++) memA[i] = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) memB[i] = 32'hDEADBEEF;
    wrA = 0; wrB = 0; dblA = 0; dblB = 0;
    reset = 1'b0;
    #1;
    check("rel_ready_low", aReady, 0);
    @(posedge clk);
    #1;
    check("rel_ready_high", aReady, 1);
  endtask

  task automatic setR(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
    in_fmt = 2'd0; in_op = 6'h3F; in_rs = rs; in_rt = rt; in_rd = rd;
    in_shamt = sh; in_funct = fn; in_imm = 16'hABCD; in_target = 26'h2AAAAAA;
  endtask

  task automatic setI(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    in_fmt = 2'd1; in_op = op; in_rs = rs; in_rt = rt; in_rd = 5'h1F;
    in_shamt = 5'h1F; in_funct = 6'h3F; in_imm = imm; in_target = 26'h3FFFFFF;
  endtask

  task automatic setJ(input logic [5:0] op, input logic [25:0] tgt);
    in_fmt = 2'd2; in_op = op; in_rs = 5'h1F; in_rt = 5'h1F; in_rd = 5'h1F;
    in_shamt = 5'h1F; in_funct = 6'h3F; in_imm = 16'hFFFF; in_target = tgt;
  endtask

  task automatic setBad();
    in_fmt = 2'd3; in_op = 6'h23; in_rs = 5'd1; in_rt = 5'd2; in_imm = 16'h1234;
  endtask

  // Presents the current fields; returns #1 after the accepting edge, or after a 20-cycle budget.
  task automatic beat(input logic last, input bit useB, input bit expectAccept,
                      input bit holdValid, output int waits);
    bit accepted;
    accepted = 1'b0;
    waits    = 0;
    in_last  = last;
    in_valid = 1'b1;
    while (!accepted && waits < 20) begin
      @(negedge clk);
      if (useB ? bReady : aReady) begin
        @(posedge clk);
        #1;
        accepted = 1'b1;
      end else begin
        waits++;
      end
    end
    if (!holdValid || !accepted) in_valid = 1'b0;
    check("accepted", accepted, expectAccept);
  endtask

  int w;

  initial begin
    // R-format add
    doReset();
    setR(5'd8, 5'd9, 5'd10, 5'd0, 6'h20);
    beat(1'b0, 1'b0, 1'b1, 1'b0, w);
    check("add_we", aWe, 1);
    check("add_addr", aAddr, 0);
    check("add_wd", aWd, 32'h01095020);
    check("add_ready_busy", aReady, 0);
    @(posedge clk); #1;
    check("add_we_drop", aWe, 0);
    check("add_count", aCount, 1);
    check("add_wd_hold", aWd, 32'h01095020);
    check("add_addr_hold", aAddr, 0);
    check("add_writes", wrA, 1);
    check("add_dbl", dblA, 0);

    // lw / bne / j program
    doReset();
    setI(6'h23, 5'd16, 5'd8, 16'd4);
    beat(1'b0, 1'b0, 1'b1, 1'b0, w);
    setI(6'h05, 5'd8, 5'd9, 16'hFFFF);
    beat(1'b0, 1'b0, 1'b1, 1'b0, w);
    setJ(6'h02, 26'h10);
    beat(1'b1, 1'b0, 1'b1, 1'b0, w);
    check("prog_addr2", aAddr, 2);
    check("prog_cpurst_busy", aCpuRst, 1);
    @(posedge clk); #1;
    check("prog_done", aDone, 1);
    check("prog_cpurst", aCpuRst, 0);
    check("prog_count", aCount, 3);
    check("prog_ready", aReady, 0);
    check("prog_w0", memA[0], 32'h8E080004);
    check("prog_w1", memA[1], 32'h1509FFFF);
    check("prog_w2", memA[2], 32'h08000010);
    setI(6'h08, 5'd1, 5'd1, 16'd1);
    beat(1'b0, 1'b0, 1'b0, 1'b0, w);
    check("prog_no_more_writes", wrA, 3);

    // in_valid held high across 4 beats
    doReset();
    for (int i = 0; i < 4; i++) begin
      setI(6'h08, 5'd1, 5'd2, 16'(i * 17 + 1));
      beat(1'b0, 1'b0, 1'b1, 1'b1, w);
      if (i > 0) check("held_gap", w, 1);
      check("held_ready_low", aReady, 0);
    end
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("held_writes", wrA, 4);
    check("held_dbl", dblA, 0);
    check("held_count", aCount, 4);
    for (int i = 0; i < 4; i++) check("held_word", memA[i], 32'h20220000 | 32'(i * 17 + 1));

    // illegal format between two legal beats
    doReset();
    setR(5'd1, 5'd2, 5'd3, 5'd4, 6'd5);
    beat(1'b0, 1'b0, 1'b1, 1'b0, w);
    setBad();
    beat(1'b0, 1'b0, 1'b1, 1'b0, w);
    check("bad_no_we", aWe, 0);
    check("bad_fmterr", aFmtErr, 1);
    setJ(6'h03, 26'h3FFFFFF);
    beat(1'b0, 1'b0, 1'b1, 1'b0, w);
    repeat (2) begin @(posedge clk); #1; end
    check("bad_w0", memA[0], 32'h00221905);
    check("bad_w1", memA[1], 32'h0FFFFFFF);
    check("bad_count", aCount, 2);
    check("bad_writes", wrA, 2);
    check("bad_not_done", aDone, 0);

    // illegal format with in_last goes straight to DONE
    doReset();
    setBad();
    beat(1'b1, 1'b0, 1'b1, 1'b0, w);
    check("badlast_done", aDone, 1);
    check("badlast_fmterr", aFmtErr, 1);
    check("badlast_count", aCount, 0);
    check("badlast_we", aWe, 0);

    // overflow: 4-word memory, no in_last
    doReset();
    for (int i = 0; i < 4; i++) begin
      setI(6'h08, 5'd0, 5'(i), 16'(i));
      beat(1'b0, 1'b1, 1'b1, 1'b0, w);
    end
    check("ovf_addr3", bAddr, 3);
    @(posedge clk); #1;
    check("ovf_flag", bOvf, 1);
    check("ovf_done", bDone, 1);
    check("ovf_count", bCount, 4);
    for (int i = 0; i < 4; i++) check("ovf_word", memB[i], 32'h20000000 | (32'(i) << 16) | 32'(i));
    setI(6'h08, 5'd0, 5'd0, 16'h5555);
    beat(1'b0, 1'b1, 1'b0, 1'b0, w);
    check("ovf_writes", wrB, 4);
    check("ovf_dbl", dblB, 0);

    // full on the in_last beat: no overflow
    doReset();
    for (int i = 0; i < 4; i++) begin
      setI(6'h08, 5'd0, 5'(i), 16'(i));
      beat(i == 3, 1'b1, 1'b1, 1'b0, w);
    end
    @(posedge clk); #1;
    check("full_last_ovf", bOvf, 0);
    check("full_last_done", bDone, 1);
    check("full_last_count", bCount, 4);

    // reset in the middle of a write
    doReset();
    setR(5'd8, 5'd9, 5'd10, 5'd0, 6'h20);
    beat(1'b0, 1'b0, 1'b1, 1'b0, w);
    check("mid_we_before", aWe, 1);
    #1 reset = 1'b1;
    #1;
    check("mid_we_abort", aWe, 0);
    check("mid_count", aCount, 0);
    check("mid_addr", aAddr, 0);
    check("mid_cpurst", aCpuRst, 1);
    doReset();
    setJ(6'h02, 26'h10);
    beat(1'b1, 1'b0, 1'b1, 1'b0, w);
    check("fresh_addr", aAddr, 0);
    @(posedge clk); #1;
    check("fresh_w0", memA[0], 32'h08000010);
    check("fresh_done", aDone, 1);
    check("fresh_count", aCount, 1);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

endmodule
